subtractor_pipe: RTL and testbench

Pipelined 8-bit two's-complement subtractor, the inverse datapath to the team's combinational prefix-tree `adder`. Computes `diff = a_in - b_in` with a borrow-lookahead prefix tree split over two registered stages, behind valid/ready handshakes on both sides. Sustains one result per cycle and stalls cleanly under downstream backpressure. Sits between an operand-producing client and a result consumer in the same datapath tiles as `adder`.

---
 rtl/subtractor_pipe.sv | 150 +++++++++++++++
 tb/tb_subtractor_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_pipe.sv
// Two-stage pipelined subtractor: borrow generate/propagate in S1, prefix tree and result in S2.
// Optional zero/overflow flags are built only when SUBTRACTOR_PIPE_FLAGS_EN is defined.
module subtractor_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned Levels = $clog2(WIDTH);

  // Stage 1 state
  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] g_q, p_q, x_q;
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
  logic             sa_q, sb_q;
`endif

  // Stage 2 state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  logic             s2_load;
  logic             in_fire;
  logic [WIDTH-1:0] g_lvl, p_lvl, g_nxt, p_nxt;

  assign s2_load  = s1_v_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_v_q | s2_load;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    s1_v_d = s1_v_q;
    if (in_fire) begin
      s1_v_d = 1'b1;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      g_q    <= '0;
      p_q    <= '0;
      x_q    <= '0;
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
`endif
    end else begin
      s1_v_q <= s1_v_d;
      if (in_fire) begin
        g_q <= ~a_in & b_in;
        p_q <= ~(a_in ^ b_in);
        x_q <= a_in ^ b_in;
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
        sa_q <= a_in[WIDTH-1];
        sb_q <= b_in[WIDTH-1];
`endif
      end
    end
  end

  // Kogge-Stone borrow tree; g_lvl[i] ends as the borrow out of bit i with no borrow-in.
  always_comb begin
    g_lvl = g_q;
    p_lvl = p_q;
    g_nxt = g_q;
    p_nxt = p_q;
    for (int l = 0; l < Levels; l++) begin
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << l)) begin
          g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i - (1 << l)]);
          p_nxt[i] = p_lvl[i] & p_lvl[i - (1 << l)];
        end
      end
      g_lvl = g_nxt;
      p_lvl = p_nxt;
    end
  end

  always_comb begin
    diff_d   = x_q ^ {g_lvl[WIDTH-2:0], 1'b0};
    borrow_d = g_lvl[WIDTH-1];
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
    zero_d   = (diff_d == '0);
    ovf_d    = (sa_q != sb_q) & (diff_d[WIDTH-1] != sa_q);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
        zero_q   <= zero_d;
        ovf_q    <= ovf_d;
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_pipe.sv
// Self-checking bench for subtractor_pipe: directed vectors, backpressure, reset, random and
// exhaustive streams against an arithmetic reference model.
module tb_subtractor_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, borrow;
  logic       zero_s, ovf_s;
  logic [7:0] a_in, b_in, diff;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q [$];

`ifdef SUBTRACTOR_PIPE_FLAGS_EN
  localparam logic [10:0] Mask = 11'h7FF;
`else
  localparam logic [10:0] Mask = 11'h1FF;
`endif

  // Directed vectors: a, b, expected {ovf, zero, borrow, diff}
  logic [7:0]  tab_a [6] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h5A, 8'h7F};
  logic [7:0]  tab_b [6] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h5A, 8'hFF};
  logic [10:0] tab_e [6] = '{11'h002, 11'h1FE, 11'h1FF, 11'h47F, 11'h200, 11'h580};

  subtractor_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SUBTRACTOR_PIPE_FLAGS_EN
    ,
    .zero      (zero_s),
    .ovf       (ovf_s)
`endif
  );

`ifndef SUBTRACTOR_PIPE_FLAGS_EN
  assign zero_s = 1'b0;
  assign ovf_s  = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // {ovf, zero, borrow, diff} from plain signed/unsigned arithmetic
  function automatic logic [10:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    int         sd;
    logic       o;
    r  = {1'b0, a} - {1'b0, b};
    sd = int'($signed(a)) - int'($signed(b));
    o  = (sd > 127) || (sd < -128);
    return {o, (r[7:0] == 8'h00), r};
  endfunction

  function automatic logic [10:0] obs();
    return {ovf_s, zero_s, borrow, diff};
  endfunction

  // Drive one operand into an empty pipe with out_ready=1; lat = edges until out_valid.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b,
                         output logic [10:0] got, output int lat);
    logic acc;
    got = '0;
    lat = -1;
    @(negedge clk);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b1;
    #1 acc = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (acc) begin
      for (int k = 1; k <= 8; k++) begin
        if (out_valid) begin
          lat = k;
          got = obs();
          break;
        end
        @(negedge clk);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || (obs() & Mask) !== 11'h000) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b outs=%h required 1 0 000",
               in_ready, out_valid, obs() & Mask);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [10:0] got;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_one(tab_a[i], tab_b[i], got, lat);
      total++;
      if ((got & Mask) !== (tab_e[i] & Mask)) begin
        bad++;
        $display("FAIL basic_value[%0d] %h-%h: got %h required %h", i, tab_a[i], tab_b[i],
                 got & Mask, tab_e[i] & Mask);
      end
      total++;
      if (lat != 2) begin
        bad++;
        $display("FAIL basic_latency[%0d]: got %0d required 2", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  oa [3];
    logic [7:0]  ob [3];
    logic [10:0] e;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      oa[i] = 8'($urandom);
      ob[i] = 8'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a_in      = oa[i];
      b_in      = ob[i];
      #1;
      total++;
      if (in_ready !== (i < 2)) begin
        bad++;
        $display("FAIL bp_in_ready[%0d]: got %b required %b", i, in_ready, (i < 2));
      end
      if (in_valid && in_ready) exp_q.push_back(ref_sub(oa[i], ob[i]));
      @(posedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || (obs() & Mask) !== (exp_q[0] & Mask)) begin
        bad++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out=%h required 1 0 %h", c,
                 out_valid, in_ready, obs() & Mask, exp_q[0] & Mask);
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready: got %b required 1", in_ready);
    end
    if (in_valid && in_ready) exp_q.push_back(ref_sub(oa[2], ob[2]));
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      if (k > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
      end
      if (out_valid) begin
        e = exp_q.pop_front();
        total++;
        if ((obs() & Mask) !== (e & Mask)) begin
          bad++;
          $display("FAIL bp_drain[%0d]: got %h required %h", k, obs() & Mask, e & Mask);
        end
      end
      @(posedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_drain_count: %0d results missing required 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    int          sent = 0;
    int          recv = 0;
    logic        hold = 1'b0;
    logic [10:0] prev = '0;
    logic [10:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 4000 && recv < 256; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 256) && ($urandom_range(0, 3) != 0);
      a_in      = 8'($urandom);
      b_in      = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (hold) begin
        total++;
        if (out_valid !== 1'b1 || obs() !== prev) begin
          bad++;
          $display("FAIL rnd_stable: out_valid=%b out=%h required 1 %h", out_valid, obs(), prev);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra: unexpected result %h required none", obs() & Mask);
        end else begin
          e = exp_q.pop_front();
          if ((obs() & Mask) !== (e & Mask)) begin
            bad++;
            $display("FAIL rnd_value[%0d]: got %h required %h", recv, obs() & Mask, e & Mask);
          end
        end
        recv++;
      end
      hold = out_valid && !out_ready;
      prev = obs();
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(a_in, b_in));
        sent++;
      end
      @(posedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (recv != 256 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_count: received %0d pending %0d required 256 0", recv, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic [10:0] got;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a_in      = (i == 0) ? 8'h33 : 8'h44;
      b_in      = 8'h11;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h22) begin
      bad++;
      $display("FAIL rst_mid_full: out_valid=%b in_ready=%b diff=%h required 1 0 22",
               out_valid, in_ready, diff);
    end
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || (obs() & Mask) !== 11'h000 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_async: out_valid=%b outs=%h in_ready=%b required 0 000 1",
               out_valid, obs() & Mask, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    run_one(8'h10, 8'h01, got, lat);
    total++;
    if ((got & Mask) !== 11'h00F || lat != 2) begin
      bad++;
      $display("FAIL rst_mid_next: got %h lat %0d required 00f lat 2", got & Mask, lat);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_no_stale: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_exhaustive();
    int          recv    = 0;
    int          bubbles = 0;
    int          stalls  = 0;
    logic [10:0] e;
    exp_q.delete();
    for (int n = 0; n < 65536 + 8 && recv < 65536; n++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (n < 65536) begin
        in_valid = 1'b1;
        a_in     = n[15:8];
        b_in     = n[7:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) stalls++;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL exh_extra: unexpected result %h required none", obs() & 11'h1FF);
        end else begin
          e = exp_q.pop_front();
          if ((obs() & 11'h1FF) !== (e & 11'h1FF)) begin
            bad++;
            $display("FAIL exh_value[%0d]: got %h required %h", recv, obs() & 11'h1FF,
                     e & 11'h1FF);
          end
        end
        recv++;
      end else if (n >= 2 && n < 65536) begin
        bubbles++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_sub(a_in, b_in));
      @(posedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (recv != 65536 || bubbles != 0 || stalls != 0) begin
      bad++;
      $display("FAIL exh_stream: recv=%0d bubbles=%0d stalls=%0d required 65536 0 0",
               recv, bubbles, stalls);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d %s", total, bad, (bad == 0) ? "PASS" : "FAIL");
    $finish;
  end

endmodule
